// File: rtl/time_set_ctrl.sv
// Time-setting controller: synchronises and debounces the mode/inc buttons and edits hour/minute for the time counters.
// Optional auto-repeat on a held inc button is built when TIME_SET_AUTO_REPEAT_EN is defined.
module time_set_ctrl #(
    parameter logic [15:0] DB_CYCLES     = 16'd50000,
    parameter logic [5:0]  TIMEOUT_TICKS = 6'd30,
    parameter logic [2:0]  REPEAT_DELAY  = 3'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_minute,
    output logic [1:0] set_state,
    output logic       blink
);

    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned DBW      = 16;
    localparam int unsigned IDLEW    = 6;

    localparam logic [DBW-1:0]   DB_LAST      = DB_CYCLES - 16'd1;
    localparam logic [IDLEW-1:0] TIMEOUT_LAST = TIMEOUT_TICKS - 6'd1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t            state;
    logic [NBTN-1:0]   sync_1;
    logic [NBTN-1:0]   sync_2;
    logic [NBTN-1:0]   db_level;
    logic [NBTN-1:0]   db_prev;
    logic [DBW-1:0]    db_cnt [NBTN];
    logic [IDLEW-1:0]  idle_cnt;
    logic [NBTN-1:0]   press_c;
    logic              mode_press_c;
    logic              inc_press_c;
    logic              repeat_c;
    logic              inc_ev_c;

    // Synchroniser and debouncer: a level is accepted after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1   <= '0;
            sync_2   <= '0;
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1  <= {btn_inc, btn_mode};
            sync_2  <= sync_1;
            db_prev <= db_level;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign press_c      = db_level & ~db_prev;
    assign mode_press_c = press_c[BTN_MODE];
    assign inc_press_c  = press_c[BTN_INC];

`ifdef TIME_SET_AUTO_REPEAT_EN
    logic [2:0] hold_ticks;

    // Counts ticks while inc stays held in a set state; saturates at the repeat threshold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_ticks <= '0;
        end else if (!db_level[BTN_INC] || (state == ST_RUN)) begin
            hold_ticks <= '0;
        end else if (tick && (hold_ticks < REPEAT_DELAY)) begin
            hold_ticks <= hold_ticks + 3'd1;
        end
    end

    assign repeat_c = tick && (state != ST_RUN) && db_level[BTN_INC] &&
                      (hold_ticks >= REPEAT_DELAY);
`else
    logic unused_repeat_delay;
    assign unused_repeat_delay = ^REPEAT_DELAY;
    assign repeat_c            = 1'b0;
`endif

    assign inc_ev_c = inc_press_c | repeat_c;

    // Edit state machine; mode beats inc, and any press overrides the idle timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            run_en      <= 1'b1;
            load        <= 1'b0;
            load_hour   <= '0;
            load_minute <= '0;
            blink       <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (mode_press_c) begin
                        state       <= ST_SET_HOUR;
                        run_en      <= 1'b0;
                        load_hour   <= cur_hour;
                        load_minute <= cur_minute;
                        blink       <= 1'b0;
                        idle_cnt    <= '0;
                    end
                end
                ST_SET_HOUR, ST_SET_MIN: begin
                    if (mode_press_c) begin
                        blink    <= 1'b0;
                        idle_cnt <= '0;
                        if (state == ST_SET_HOUR) begin
                            state <= ST_SET_MIN;
                        end else begin
                            state  <= ST_RUN;
                            run_en <= 1'b1;
                            load   <= 1'b1;
                        end
                    end else if (inc_ev_c) begin
                        idle_cnt <= '0;
                        blink    <= blink ^ tick;
                        if (state == ST_SET_HOUR) begin
                            load_hour <= (load_hour == 5'd23) ? 5'd0 : load_hour + 5'd1;
                        end else begin
                            load_minute <= (load_minute == 6'd59) ? 6'd0 : load_minute + 6'd1;
                        end
                    end else if (tick && (idle_cnt == TIMEOUT_LAST)) begin
                        state    <= ST_RUN;
                        run_en   <= 1'b1;
                        blink    <= 1'b0;
                        idle_cnt <= '0;
                    end else if (tick) begin
                        idle_cnt <= idle_cnt + IDLEW'(1);
                        blink    <= ~blink;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    run_en <= 1'b1;
                    blink  <= 1'b0;
                end
            endcase
        end
    end

    assign set_state = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a behavioural model queues every expected output change, a monitor pops and compares.
module tb_time_set_ctrl;

    localparam logic [15:0] DB      = 16'd4;
    localparam int          HOLD    = int'(DB) + 8;
    localparam int          TIMEOUT = 30;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int          REP     = 2;
`endif

    typedef logic [15:0] obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_minute = 6'd0;
    logic       run_en;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_minute;
    logic [1:0] set_state;
    logic       blink;

    always #5 clock = ~clock;

    time_set_ctrl #(
        .DB_CYCLES    (DB),
        .TIMEOUT_TICKS(6'd30),
        .REPEAT_DELAY (3'd2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .tick       (tick),
        .cur_hour   (cur_hour),
        .cur_minute (cur_minute),
        .run_en     (run_en),
        .load       (load),
        .load_hour  (load_hour),
        .load_minute(load_minute),
        .set_state  (set_state),
        .blink      (blink)
    );

    int tests = 0;
    int fails = 0;
    obs_t exp_q[$];

    // Reference model: mode 0 run, 1 editing hour, 2 editing minute
    int   m_mode = 0;
    int   m_hour = 0;
    int   m_min = 0;
    int   m_idle = 0;
    int   m_held = 0;
    bit   m_inc_held = 0;
    bit   m_blink = 0;

    function automatic obs_t pack(int st, int ren, int ld, int h, int m, int bl);
        return {2'(st), 1'(ren), 1'(ld), 5'(h), 6'(m), 1'(bl)};
    endfunction

    obs_t last_push = pack(0, 1, 0, 0, 0, 0);

    function automatic obs_t model_obs();
        return pack(m_mode, (m_mode == 0) ? 1 : 0, 0, m_hour, m_min, m_blink ? 1 : 0);
    endfunction

    function automatic void push(obs_t o);
        if (o != last_push) begin
            exp_q.push_back(o);
            last_push = o;
        end
    endfunction

    function automatic void model_mode_press();
        m_blink = 0;
        m_idle  = 0;
        m_held  = 0;
        if (m_mode == 0) begin
            m_hour = int'(cur_hour);
            m_min  = int'(cur_minute);
            m_mode = 1;
            push(model_obs());
        end else if (m_mode == 1) begin
            m_mode = 2;
            push(model_obs());
        end else begin
            m_mode = 0;
            push(pack(0, 1, 1, m_hour, m_min, 0));
            push(model_obs());
        end
    endfunction

    function automatic void model_inc(bit with_tick);
        if (m_mode == 0) return;
        if (m_mode == 1) m_hour = (m_hour + 1) % 24;
        else             m_min  = (m_min + 1) % 60;
        m_idle = 0;
        if (with_tick) m_blink = !m_blink;
        push(model_obs());
    endfunction

    function automatic void model_tick();
        if (m_mode == 0) return;
`ifdef TIME_SET_AUTO_REPEAT_EN
        if (m_inc_held) begin
            m_held++;
            if (m_held > REP) begin
                model_inc(1);
                return;
            end
        end
`endif
        if (m_idle == TIMEOUT - 1) begin
            m_mode  = 0;
            m_blink = 0;
            m_idle  = 0;
        end else begin
            m_idle++;
            m_blink = !m_blink;
        end
        push(model_obs());
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_hour = 0; m_min = 0; m_idle = 0; m_held = 0; m_blink = 0;
        push(model_obs());
    endfunction

    // Monitor: every change of the observed outputs must match the next queued expectation
    bit   mon_en = 0;
    obs_t prev_obs = pack(0, 1, 0, 0, 0, 0);
    obs_t cur_obs;
    obs_t exp_obs;
    int   load_run = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            cur_obs = {set_state, run_en, load, load_hour, load_minute, blink};
            if (load) begin
                load_run++;
            end else if (load_run != 0) begin
                tests++;
                if (load_run != 1) begin
                    fails++;
                    $display("FAIL load_width got=%0d cycles exp=1", load_run);
                end
                load_run = 0;
            end
            if (cur_obs != prev_obs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change got=%h exp=none at %0t", cur_obs, $time);
                end else begin
                    exp_obs = exp_q.pop_front();
                    if (exp_obs != cur_obs) begin
                        fails++;
                        $display("FAIL output_change got=%h exp=%h at %0t", cur_obs, exp_obs, $time);
                    end
                end
                prev_obs = cur_obs;
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic press(bit pm, bit pi);
        if (pm)      model_mode_press();
        else if (pi) model_inc(0);
        btn_mode = pm;
        btn_inc  = pi;
        cycles(HOLD);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(HOLD);
    endtask

    task automatic tick_pulse();
        model_tick();
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
        cycles(2);
    endtask

    // Inc press whose debounced edge lands on the same edge as a tick
    task automatic inc_on_tick();
        model_inc(1);
        btn_inc = 1'b1;
        cycles(int'(DB) + 2);
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
        cycles(HOLD);
        btn_inc = 1'b0;
        cycles(HOLD);
    endtask

    task automatic mid_reset();
        model_reset();
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);
    endtask

    initial begin
        int r;
        cycles(3);
        check("reset_state", int'({set_state, run_en, load, load_hour, load_minute, blink}),
              int'(pack(0, 1, 0, 0, 0, 0)));
        reset = 1'b1;
        cycles(2);
        mon_en = 1;

        // Enter edit, hour wrap, minute wrap, commit 00:00
        cur_hour = 5'd13; cur_minute = 6'd45;
        press(1, 0);
        check("enter_hour", int'(load_hour), 13);
        for (int i = 0; i < 11; i++) press(0, 1);
        check("hour_wrap", int'(load_hour), 0);
        press(1, 0);
        for (int i = 0; i < 15; i++) press(0, 1);
        check("minute_wrap", int'(load_minute), 0);
        press(1, 0);

        // Short glitch on inc while editing minutes
        cur_hour = 5'd7; cur_minute = 6'd20;
        press(1, 0);
        press(1, 0);
        btn_inc = 1'b1;
        cycles(int'(DB) - 1);
        btn_inc = 1'b0;
        cycles(HOLD);
        check("glitch_ignored", int'(load_minute), 20);
        press(1, 0);

        // Idle timeout discards the edit
        cur_hour = 5'd9; cur_minute = 6'd5;
        press(1, 0);
        press(0, 1);
        for (int i = 0; i < TIMEOUT; i++) tick_pulse();
        check("timeout_state", int'(set_state), 0);

        // Press coincides with the timeout tick
        press(1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick_pulse();
        inc_on_tick();
        check("press_beats_timeout", int'(set_state), 1);
        tick_pulse();
        press(1, 0);
        press(1, 0);

        // Mode and inc together, then reset in the middle of an edit
        cur_hour = 5'd16; cur_minute = 6'd33;
        press(1, 0);
        press(1, 1);
        check("mode_wins_hour", int'(load_hour), 16);
        mid_reset();

        // Held inc over five ticks in minute edit
        cur_hour = 5'd5; cur_minute = 6'd10;
        press(1, 0);
        press(1, 0);
        model_inc(0);
        m_inc_held = 1;
        m_held = 0;
        btn_inc = 1'b1;
        cycles(HOLD);
        for (int i = 0; i < 5; i++) tick_pulse();
        m_inc_held = 0;
        btn_inc = 1'b0;
        cycles(HOLD);
`ifdef TIME_SET_AUTO_REPEAT_EN
        check("held_inc", int'(load_minute), 14);
`else
        check("held_inc", int'(load_minute), 11);
`endif
        press(1, 0);

        // Randomised mix of presses and tick bursts
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 9));
            cur_hour   = 5'($urandom_range(0, 23));
            cur_minute = 6'($urandom_range(0, 59));
            if (r <= 2)      press(1, 0);
            else if (r <= 5) press(0, 1);
            else if (r == 6) press(1, 1);
            else if (r == 9) for (int k = 0; k < 31; k++) tick_pulse();
            else begin
                int nt;
                nt = int'($urandom_range(1, 8));
                for (int k = 0; k < nt; k++) tick_pulse();
            end
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
        cycles(4);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16'd50000: number of consecutive stable synchronized samples before a button level is accepted.
REQ-002 Parameter TIMEOUT_TICKS, default 6'd30: number of idle ticks in a set state before the block abandons the edit.
REQ-003 Parameter REPEAT_DELAY, default 3'd2: number of ticks inc must be held before auto-repeat starts (only with AUTO_REPEAT_EN).
REQ-004 clock  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_mode  input  1  raw mode button, asynchronous, active-high.
REQ-007 btn_inc  input  1  raw increment button, asynchronous, active-high.
REQ-008 tick  input  1  one-cycle pulse per second from the timebase.
REQ-009 cur_hour  input  5  running hour, 0..23.
REQ-010 cur_minute  input  6  running minute, 0..59.
REQ-011 run_en  output  1  time counters advance when 1.
REQ-012 load  output  1  one-cycle strobe: the time counters take load_hour/load_minute.
REQ-013 load_hour  output  5  edited hour.
REQ-014 load_minute  output  6  edited minute.
REQ-015 set_state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-016 blink  output  1  display blank phase for the field being edited.

Function
REQ-017 Each button passes through a 2-flop synchronizer, then a debouncer that accepts a new level only after DB_CYCLES identical consecutive samples.
REQ-018 A press is a single-cycle pulse generated on the 0->1 transition of the debounced level; a release generates nothing.
REQ-019 RUN + mode press -> SET_HOUR, and load_hour/load_minute capture cur_hour/cur_minute in the same edge.
REQ-020 SET_HOUR + mode press -> SET_MIN.
REQ-021 SET_MIN + mode press -> RUN, with load=1 for exactly the cycle after the transition edge.
REQ-022 run_en=0 in SET_HOUR and SET_MIN; run_en=1 in RUN, including the cycle in which load is asserted.
REQ-023 SET_HOUR + inc press -> load_hour+1, wrapping 23->0.
REQ-024 SET_MIN + inc press -> load_minute+1, wrapping 59->0.
REQ-025 In RUN, inc presses are ignored.
REQ-026 Mode and inc press in the same cycle: mode wins and inc is discarded.
REQ-027 A 6-bit idle counter clears on every press and on entry to a set state, and increments on each tick while in a set state.
REQ-028 When the idle counter reaches TIMEOUT_TICKS, the state -> RUN with load held at 0, so the edit is discarded.
REQ-029 blink toggles on each tick while in a set state; blink is forced 0 in RUN and on entry to a set state.
REQ-030 A press arriving on the same cycle as the timeout tick is processed, and the timeout is suppressed for that cycle.

Reset
REQ-031 While reset is low: state=RUN, run_en=1, load=0, load_hour=0, load_minute=0, set_state=00, blink=0, idle counter=0.
REQ-032 While reset is low: debounced levels=0, synchronizers=0, debounce counters=0.
REQ-033 Reset asserted mid-edit discards the edit and produces no load pulse.

Configuration
REQ-034 Macro TIME_SET_AUTO_REPEAT_EN defined: once the debounced inc level has been held high for REPEAT_DELAY ticks in a set state, each subsequent tick acts as an inc press until release.
REQ-035 Auto-repeat increments reset the idle counter in the same way as a real press.
REQ-036 Macro TIME_SET_AUTO_REPEAT_EN undefined: no auto-repeat logic is built, and holding inc yields exactly one increment.

Verification
REQ-037 DB_CYCLES=4; reset; cur=13:45; press mode -> set_state=01, run_en=0, load_hour=13, load_minute=45.
REQ-038 From SET_HOUR with load_hour=23, press inc -> load_hour=0; press mode, inc x15 from 45 -> load_minute=0; press mode -> single-cycle load with 00:00, run_en=1.
REQ-039 btn_inc glitch of 3 cycles (less than DB_CYCLES) in SET_MIN -> load_minute unchanged.
REQ-040 Enter SET_HOUR, apply 30 ticks with no press -> set_state=00, load never asserted; blink toggled 29 times, then 0.
REQ-041 Mode and inc pulses on the same cycle in SET_HOUR -> set_state=10, load_hour unchanged; reset asserted in SET_MIN -> all outputs at reset values.
REQ-042 With TIME_SET_AUTO_REPEAT_EN, hold inc 5 ticks in SET_MIN starting at 10 -> load_minute=14 (1 press + 3 repeats); without the macro -> load_minute=11.
